// File: rtl/mw_lsu_pkg.sv
// Shared types and helpers for the memory/writeback load-store unit.
// Misaligned-access trapping in the top level is enabled by defining MW_MISALIGN_TRAP_EN.
package mw_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_e;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] a);
        logic r;
        case (funct3[1:0])
            2'b01:   r = a[0];
            2'b10:   r = (a != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mw_lsu_align.sv
// Combinational lane steering: store data/strobes toward the bus, load extraction and
// sign/zero extension back toward writeback.
module mw_lsu_align
    import mw_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] ld_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        wdata = st_data;
        wstrb = 4'hF;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{st_data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            2'b01: begin
                wdata = {2{st_data[15:0]}};
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_ext = rdata;
        case (funct3)
            F3_B:    ld_ext = {{24{w_byte[7]}}, w_byte};
            F3_H:    ld_ext = {{16{w_half[15]}}, w_half};
            F3_W:    ld_ext = rdata;
            F3_BU:   ld_ext = {24'h0, w_byte};
            F3_HU:   ld_ext = {16'h0, w_half};
            default: ld_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mw_load_store_unit.sv
// Memory/writeback load-store unit: bus FSM, timeout, stall and registered writeback.
// Define MW_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of truncating them.
module mw_load_store_unit
    import mw_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ALUResult_MW,
    input  logic [31:0]       rdata2_MW,
    input  logic [4:0]        waddr_MW,
    input  logic              mem_read_MW,
    input  logic              mem_write_MW,
    input  logic [2:0]        funct3_MW,
    output logic              Stall_MW,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [31:0]       dbus_wdata,
    output logic [3:0]        dbus_wstrb,
    input  logic              dbus_gnt,
    input  logic              dbus_rvalid,
    input  logic [31:0]       dbus_rdata,
    output logic              ld_valid,
    output logic [4:0]        ld_waddr,
    output logic [31:0]       ld_data,
    output logic              bus_err
`ifdef MW_MISALIGN_TRAP_EN
    ,
    output logic              misalign,
    output logic [31:0]       misalign_addr
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic           r_ld_valid, r_bus_err;
    logic [4:0]     r_ld_waddr;
    logic [31:0]    r_ld_data;

    logic        w_op, w_store, w_mis, w_req, w_wait, w_timeout, w_complete;
    logic [31:0] w_wdata, w_ld_ext;
    logic [3:0]  w_wstrb;

    assign w_op    = mem_read_MW | mem_write_MW;
    assign w_store = mem_write_MW;
`ifdef MW_MISALIGN_TRAP_EN
    assign w_mis   = w_op && is_misaligned(funct3_MW, ALUResult_MW[1:0]);
`else
    assign w_mis   = 1'b0;
`endif

    mw_lsu_align u_align (
        .addr_lo (ALUResult_MW[1:0]),
        .funct3  (funct3_MW),
        .st_data (rdata2_MW),
        .rdata   (dbus_rdata),
        .wdata   (w_wdata),
        .wstrb   (w_wstrb),
        .ld_ext  (w_ld_ext)
    );

    assign w_wait    = (r_state == REQ && !dbus_gnt) || (r_state == RESP && !dbus_rvalid);
    assign w_timeout = w_wait && (r_cnt == TMO_LAST);

    always_comb begin
        w_complete = 1'b0;
        case (r_state)
            IDLE:    w_complete = w_op && (w_mis || (dbus_gnt && w_store));
            REQ:     w_complete = (dbus_gnt && w_store) || w_timeout;
            RESP:    w_complete = dbus_rvalid || w_timeout;
            default: w_complete = 1'b0;
        endcase
    end

    // Reset gates the bus and stall combinationally so an in-flight request drops at once.
    assign w_req      = !rst && ((r_state == IDLE && w_op && !w_mis) || r_state == REQ);
    assign Stall_MW   = !rst && w_op && !w_complete;
    assign dbus_req   = w_req;
    assign dbus_we    = w_req && w_store;
    assign dbus_addr  = w_req ? {ALUResult_MW[ADDR_W-1:2], 2'b00} : '0;
    assign dbus_wdata = (w_req && w_store) ? w_wdata : 32'h0;
    assign dbus_wstrb = (w_req && w_store) ? w_wstrb : 4'h0;

    assign ld_valid = r_ld_valid;
    assign ld_waddr = r_ld_waddr;
    assign ld_data  = r_ld_data;
    assign bus_err  = r_bus_err;

`ifdef MW_MISALIGN_TRAP_EN
    logic        r_misalign;
    logic [31:0] r_misalign_addr;
    assign misalign      = r_misalign;
    assign misalign_addr = r_misalign_addr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ld_valid <= 1'b0;
            r_ld_waddr <= 5'd0;
            r_ld_data  <= 32'h0;
            r_bus_err  <= 1'b0;
`ifdef MW_MISALIGN_TRAP_EN
            r_misalign      <= 1'b0;
            r_misalign_addr <= 32'h0;
`endif
        end else begin
            r_ld_valid <= 1'b0;
            r_bus_err  <= 1'b0;
`ifdef MW_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_mis) begin
`ifdef MW_MISALIGN_TRAP_EN
                        r_misalign      <= 1'b1;
                        r_misalign_addr <= ALUResult_MW;
`endif
                    end else if (w_op && dbus_gnt) begin
                        if (!w_store) begin
                            r_state <= RESP;
                            r_cnt   <= '0;
                        end
                    end else if (w_op) begin
                        r_state <= REQ;
                        r_cnt   <= '0;
                    end
                end
                REQ: begin
                    if (dbus_gnt) begin
                        r_state <= w_store ? IDLE : RESP;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state   <= IDLE;
                        r_bus_err <= 1'b1;
                        if (!w_store) begin
                            r_ld_valid <= 1'b1;
                            r_ld_waddr <= waddr_MW;
                            r_ld_data  <= 32'h0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (dbus_rvalid) begin
                        r_state    <= IDLE;
                        r_ld_valid <= 1'b1;
                        r_ld_waddr <= waddr_MW;
                        r_ld_data  <= w_ld_ext;
                    end else if (w_timeout) begin
                        r_state    <= IDLE;
                        r_bus_err  <= 1'b1;
                        r_ld_valid <= 1'b1;
                        r_ld_waddr <= waddr_MW;
                        r_ld_data  <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mw_load_store_unit.sv
// Directed self-checking bench for mw_load_store_unit (TIMEOUT_CYC = 4).
module tb_mw_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResult_MW, rdata2_MW, dbus_rdata;
    logic [4:0]  waddr_MW;
    logic        mem_read_MW, mem_write_MW, dbus_gnt, dbus_rvalid;
    logic [2:0]  funct3_MW;
    logic        Stall_MW, dbus_req, dbus_we, ld_valid, bus_err;
    logic [31:0] dbus_addr, dbus_wdata, ld_data;
    logic [3:0]  dbus_wstrb;
    logic [4:0]  ld_waddr;
`ifdef MW_MISALIGN_TRAP_EN
    logic        misalign;
    logic [31:0] misalign_addr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mw_load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ALUResult_MW (ALUResult_MW),
        .rdata2_MW    (rdata2_MW),
        .waddr_MW     (waddr_MW),
        .mem_read_MW  (mem_read_MW),
        .mem_write_MW (mem_write_MW),
        .funct3_MW    (funct3_MW),
        .Stall_MW     (Stall_MW),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_wdata   (dbus_wdata),
        .dbus_wstrb   (dbus_wstrb),
        .dbus_gnt     (dbus_gnt),
        .dbus_rvalid  (dbus_rvalid),
        .dbus_rdata   (dbus_rdata),
        .ld_valid     (ld_valid),
        .ld_waddr     (ld_waddr),
        .ld_data      (ld_data),
        .bus_err      (bus_err)
`ifdef MW_MISALIGN_TRAP_EN
        ,
        .misalign      (misalign),
        .misalign_addr (misalign_addr)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        mem_read_MW  = 1'b0;
        mem_write_MW = 1'b0;
        ALUResult_MW = 32'h0;
        rdata2_MW    = 32'h0;
        waddr_MW     = 5'd0;
        funct3_MW    = 3'b000;
        dbus_gnt     = 1'b0;
        dbus_rvalid  = 1'b0;
        dbus_rdata   = 32'h0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] wa, input logic [2:0] f3);
        mem_read_MW  = rd;
        mem_write_MW = wr;
        ALUResult_MW = a;
        rdata2_MW    = d;
        waddr_MW     = wa;
        funct3_MW    = f3;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({Stall_MW, dbus_req, ld_valid, bus_err, ld_data, ld_waddr} !== 40'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got stall=%b req=%b ldv=%b err=%b ld=%h wa=%0d want all 0",
                     Stall_MW, dbus_req, ld_valid, bus_err, ld_data, ld_waddr);
        end
        rst = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h12345678;
        tick();
        dbus_rvalid = 1'b0;
        n_cmp++;
        if (ld_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_rvalid: got ld_valid=%b want 0", ld_valid);
        end
    endtask

    task automatic test_sw_immediate();
        drive(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 5'd0, 3'b010);
        dbus_gnt = 1'b1;
        #1;
        n_cmp++;
        if ({Stall_MW, dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb} !==
            {1'b0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF}) begin
            n_bad++;
            $display("FAIL sw_bus: got stall=%b req=%b we=%b a=%h d=%h s=%h want 0 1 1 100 deadbeef f",
                     Stall_MW, dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb);
        end
        tick();
        clear_in();
        #1;
        n_cmp++;
        if ({dbus_req, ld_valid, bus_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL sw_after: got req=%b ldv=%b err=%b want 000", dbus_req, ld_valid, bus_err);
        end
        tick();
    endtask

    task automatic test_sb_wait();
        int stalls = 0;
        drive(1'b0, 1'b1, 32'h103, 32'h000000A5, 5'd0, 3'b000);
        dbus_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) dbus_gnt = 1'b1;
            #1;
            if (Stall_MW) stalls++;
            n_cmp++;
            if ({dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb} !==
                {1'b1, 1'b1, 32'h100, 32'hA5A5A5A5, 4'b1000}) begin
                n_bad++;
                $display("FAIL sb_bus_c%0d: got req=%b we=%b a=%h d=%h s=%b want 1 1 100 a5a5a5a5 1000",
                         c, dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb);
            end
            tick();
        end
        clear_in();
        n_cmp++;
        if (stalls != 2) begin
            n_bad++;
            $display("FAIL sb_stall_cycles: got %0d want 2", stalls);
        end
        tick();
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                             input logic [31:0] exp_data, input logic [4:0] wa);
        drive(1'b1, 1'b0, a, 32'h0, wa, f3);
        dbus_gnt = 1'b1;
        #1;
        n_cmp++;
        if ({Stall_MW, dbus_req, dbus_we, dbus_addr} !== {1'b1, 1'b1, 1'b0, {a[31:2], 2'b00}}) begin
            n_bad++;
            $display("FAIL ld_req_f%0d: got stall=%b req=%b we=%b a=%h want 1 1 0 %h",
                     f3, Stall_MW, dbus_req, dbus_we, dbus_addr, {a[31:2], 2'b00});
        end
        tick();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = rd;
        #1;
        n_cmp++;
        if ({Stall_MW, dbus_req} !== 2'b00) begin
            n_bad++;
            $display("FAIL ld_resp_f%0d: got stall=%b req=%b want 0 0", f3, Stall_MW, dbus_req);
        end
        tick();
        clear_in();
        n_cmp++;
        if ({ld_valid, ld_waddr, ld_data} !== {1'b1, wa, exp_data}) begin
            n_bad++;
            $display("FAIL ld_data_f%0d: got v=%b wa=%0d d=%h want 1 %0d %h",
                     f3, ld_valid, ld_waddr, ld_data, wa, exp_data);
        end
        tick();
        n_cmp++;
        if (ld_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ld_pulse_f%0d: got ld_valid=%b want 0", f3, ld_valid);
        end
    endtask

    task automatic test_load_timeout();
        drive(1'b1, 1'b0, 32'h200, 32'h0, 5'd0, 3'b010);
        dbus_gnt = 1'b1;
        tick();
        dbus_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (Stall_MW !== (c < 3)) begin
                n_bad++;
                $display("FAIL ldto_stall_c%0d: got %b want %b", c, Stall_MW, (c < 3));
            end
            tick();
        end
        clear_in();
        n_cmp++;
        if ({bus_err, ld_valid, ld_waddr, ld_data} !== {1'b1, 1'b1, 5'd0, 32'h0}) begin
            n_bad++;
            $display("FAIL ldto_pulse: got err=%b v=%b wa=%0d d=%h want 1 1 0 0",
                     bus_err, ld_valid, ld_waddr, ld_data);
        end
        tick();
        n_cmp++;
        if ({bus_err, ld_valid, dbus_req} !== 3'b000) begin
            n_bad++;
            $display("FAIL ldto_idle: got err=%b v=%b req=%b want 000", bus_err, ld_valid, dbus_req);
        end
    endtask

    task automatic test_store_timeout();
        drive(1'b0, 1'b1, 32'h300, 32'h11223344, 5'd3, 3'b010);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (Stall_MW !== (c < 4)) begin
                n_bad++;
                $display("FAIL stto_stall_c%0d: got %b want %b", c, Stall_MW, (c < 4));
            end
            tick();
        end
        clear_in();
        n_cmp++;
        if ({bus_err, ld_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL stto_pulse: got err=%b v=%b want 1 0", bus_err, ld_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 32'h104, 32'h0, 5'd9, 3'b010);
        dbus_gnt = 1'b1;
        tick();
        dbus_gnt = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({Stall_MW, dbus_req} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_resp_comb: got stall=%b req=%b want 0 0", Stall_MW, dbus_req);
        end
        tick();
        rst = 1'b0;
        clear_in();
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hCAFEBABE;
        tick();
        dbus_rvalid = 1'b0;
        n_cmp++;
        if ({ld_valid, bus_err, ld_data} !== 34'h0) begin
            n_bad++;
            $display("FAIL rst_resp_after: got v=%b err=%b d=%h want 0 0 0", ld_valid, bus_err, ld_data);
        end
        drive(1'b0, 1'b1, 32'h108, 32'h55, 5'd0, 3'b010);
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dbus_req !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_req_comb: got req=%b want 0", dbus_req);
        end
        tick();
        rst = 1'b0;
        clear_in();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if ({bus_err, ld_valid, dbus_req} !== 3'b000) begin
                n_bad++;
                $display("FAIL rst_req_quiet_c%0d: got err=%b v=%b req=%b want 000",
                         c, bus_err, ld_valid, dbus_req);
            end
        end
        test_load(3'b100, 32'h101, 32'h0000AB00, 32'h000000AB, 5'd4);
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b0, 32'h102, 32'h0, 5'd6, 3'b010);
`ifdef MW_MISALIGN_TRAP_EN
        #1;
        n_cmp++;
        if ({Stall_MW, dbus_req} !== 2'b00) begin
            n_bad++;
            $display("FAIL mis_comb: got stall=%b req=%b want 0 0", Stall_MW, dbus_req);
        end
        tick();
        clear_in();
        n_cmp++;
        if ({misalign, misalign_addr, ld_valid} !== {1'b1, 32'h102, 1'b0}) begin
            n_bad++;
            $display("FAIL mis_pulse: got m=%b a=%h v=%b want 1 102 0", misalign, misalign_addr, ld_valid);
        end
        tick();
        n_cmp++;
        if (misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL mis_once: got %b want 0", misalign);
        end
`else
        clear_in();
        test_load(3'b010, 32'h102, 32'hCAFEF00D, 32'hCAFEF00D, 5'd6);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sw_immediate();
        test_sb_wait();
        test_load(3'b000, 32'h102, 32'h80FF7F01, 32'hFFFFFFFF, 5'd7);
        test_load(3'b100, 32'h102, 32'h80FF7F01, 32'h000000FF, 5'd8);
        test_load(3'b001, 32'h102, 32'h80FF7F01, 32'hFFFF80FF, 5'd9);
        test_load(3'b101, 32'h100, 32'h80FF7F01, 32'h00007F01, 5'd10);
        test_load(3'b000, 32'h103, 32'h80FF7F01, 32'hFFFFFF80, 5'd11);
        test_load(3'b010, 32'h100, 32'h80FF7F01, 32'h80FF7F01, 5'd12);
        test_load_timeout();
        test_store_timeout();
        test_reset_mid();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
